pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the N-stage CPU pipeline: sits beside fetch/decode and drives stall, bubble, forwarding selects and halt/drain for all stages.
- Tracks in-flight destination registers per stage (scoreboard), detects RAW hazards against the instruction in decode, and inserts bubbles.
- Detects the halt opcode, stops fetch, drains the pipeline and raises a sticky done, so benches end on done instead of polling opcode.

Parameters:
- DEPTH, 5, pipeline stages (0=fetch, 1=decode, 2=execute, ..., DEPTH-1=writeback); legal 4..8
- RA_W, 5, register address width
- OPC_W, 6, opcode width
- HALT_OPC, 6'b111111, halt opcode
- FWD_EN, 1, 1 = forwarding mode, 0 = stall-only mode
- SEL_W, 3, width of forwarding selects; must be at least clog2(DEPTH)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- clr  in  1  synchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_opc  in  OPC_W  opcode in decode
- id_rs1, id_rs2  in  RA_W each  source registers in decode
- id_use1, id_use2  in  1 each  source actually read
- id_rd  in  RA_W  destination register in decode
- id_we  in  1  decode instruction writes rd
- id_ld  in  1  decode instruction is a load (data ready end of stage 3)
- pc_en  out  1  fetch may advance PC and load the decode register
- stall  out  1  hold fetch and decode registers
- bubble  out  1  execute register loads a NOP this cycle
- fwd1_sel, fwd2_sel  out  SEL_W each  0 = register file, k = forward from output of stage k
- stage_valid  out  DEPTH  valid bit per stage; bit0 = pc_en, bit1 = id_valid
- halted  out  1  halt instruction accepted from decode
- done  out  1  halt instruction retired from writeback; sticky

Behaviour:
- Reset: clr low at a rising edge clears all scoreboard entries (valid, we, ld, rd), halted and done. Outputs after reset: pc_en=1, stall=0, bubble=0, fwd selects=0, stage_valid[DEPTH-1:2]=0. Reset mid-drain abandons the drain.
- Scoreboard: entry k (2..DEPTH-1) holds {valid, we, ld, rd, is_halt}. Each edge, entries k+1 load from entry k, so everything at stage 2 and above always advances.
- Entry 2 loads the decode fields when id_valid & !stall & !halted, otherwise a bubble (valid=0).
- A source matches entry k when valid & we & use & rd==rs & rs!=0. Register 0 never hazards or forwards.
- FWD_EN=0: hazard = any match in stages 2..DEPTH-1. The register file writes on the edge, so a writeback match still stalls.
- FWD_EN=1: hazard only when the match is entry 2 with ld=1 (load-use, 1 bubble). Otherwise fwdN_sel = lowest-index matching k in 3..DEPTH-1, or 2 for a non-load match at entry 2. The youngest producer wins.
- stall = bubble = id_valid & hazard & !halted. All selects and hazard logic are combinational from the current state and the id_* inputs.
- Halt: id_valid & id_opc==HALT_OPC & !stall sets halted on that edge. The halt enters entry 2 with we=0 and is_halt=1, and younger fetches are discarded.
- pc_en = !stall & !halted & !done.
- done sets on the edge after is_halt leaves entry DEPTH-1: exactly DEPTH-2 cycles after halted rises. It holds until clr.
- A halt arriving together with a hazard stalls first and is accepted once the hazard clears.
- Instructions in decode after halted are ignored.

Decomposition:
- Shared package pipe_pkg: HALT_OPC, NOP encoding, stage index constants (ST_IF, ST_ID, ST_EX, ...), and the scoreboard entry struct {valid, we, ld, is_halt, rd}.
- One natural sub-module, pipe_fwd_match: a per-source comparator over all entries returning hazard and select. It is instantiated twice (rs1 and rs2).

Test Plan:
- Reset: hold clr=0 for 2 edges with random id_* -> pc_en=1, stall=0, fwd selects=0, stage_valid[4:2]=0, done=0.
- FWD_EN=1, DEPTH=5: add r3 then sub using r3 on the next cycle -> stall=0, fwd1_sel=2. One cycle later, a dependent instruction -> fwd1_sel=3.
- FWD_EN=1: load r7 followed by an add reading r7 -> exactly 1 cycle of stall=bubble=1, then fwd1_sel=3.
- FWD_EN=0: add r5 followed by a dependent instruction -> stall for 3 cycles (stages 2,3,4), then fwd selects=0.
- Source r0 with a producer writing r0 -> no stall and selects 0; a producer with id_we=0 writing r5 -> no hazard.
- Halt opcode 6'b111111 accepted at edge T -> halted=1 and pc_en=0 from T; done=1 at T+3 for DEPTH=5 (T+6 for DEPTH=8). Drive clr=0 at T+1 -> halted=0, done never rises.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared constants and scoreboard entry type for the pipeline
//          control unit.
// Rev    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Halt opcode and the encoding used for an empty (bubble) slot.
  localparam logic [5:0] HALT_OPC = 6'b111111;
  localparam logic [5:0] NOP_OPC  = 6'b000000;

  // Stage indices: fetch, decode, execute, memory (load data ready at its end).
  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;

  // Widest register address a scoreboard entry can hold.
  localparam int RA_W_MAX = 8;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                valid;
    logic                we;
    logic                ld;
    logic                is_halt;
    logic [RA_W_MAX-1:0] rd;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_if
// Brief  : Decode-side instruction fields and pipeline control outputs.
//          master = pipeline datapath, slave = pipe_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int DEPTH = 5,
  parameter int RA_W  = 5,
  parameter int OPC_W = 6,
  parameter int SEL_W = 3
) ();

  // Instruction currently held in decode
  logic             id_valid;
  logic [OPC_W-1:0] id_opc;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic             id_use1;
  logic             id_use2;
  logic [RA_W-1:0]  id_rd;
  logic             id_we;
  logic             id_ld;

  // Control back to the pipeline
  logic             pc_en;
  logic             stall;
  logic             bubble;
  logic [SEL_W-1:0] fwd1_sel;
  logic [SEL_W-1:0] fwd2_sel;
  logic [DEPTH-1:0] stage_valid;
  logic             halted;
  logic             done;

  modport master (
    output id_valid, id_opc, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_we, id_ld,
    input  pc_en, stall, bubble, fwd1_sel, fwd2_sel, stage_valid, halted, done
  );

  modport slave (
    input  id_valid, id_opc, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_we, id_ld,
    output pc_en, stall, bubble, fwd1_sel, fwd2_sel, stage_valid, halted, done
  );

endinterface
`default_nettype wire

// File: rtl/pipe_fwd_match.sv
`default_nettype none
// ============================================================================
// Module : pipe_fwd_match
// Brief  : Compares one decode source register against every in-flight
//          scoreboard entry and returns the hazard flag and forward select.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 5,
  parameter int RA_W   = 5,
  parameter int SEL_W  = 3,
  parameter int FWD_EN = 1
) (
  input  sb_entry_t             sb [ST_EX:DEPTH-1],
  input  wire logic [RA_W-1:0]  rs,
  input  wire logic             use_rs,
  output logic                  hazard,
  output logic [SEL_W-1:0]      sel
);

  logic [DEPTH-1:ST_EX] w_match;
  logic [RA_W_MAX-1:0]  w_rs_ext;
  logic                 w_unused;

  assign w_rs_ext = RA_W_MAX'(rs);

  // Per-entry match; register 0 is hard-wired and never creates a dependency
  always_comb begin
    w_match = '0;
    for (int k = ST_EX; k < DEPTH; k++) begin
      w_match[k] = sb[k].valid & sb[k].we & use_rs &
                   (sb[k].rd == w_rs_ext) & (rs != '0);
    end
  end

  // Flag bits not every configuration needs, folded into a sink
  always_comb begin
    w_unused = 1'b0;
    for (int k = ST_EX; k < DEPTH; k++) begin
      w_unused = w_unused | sb[k].is_halt | sb[k].ld;
    end
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Youngest producer wins; only a load still in execute has no data yet
      always_comb begin
        hazard = 1'b0;
        sel    = '0;
        if (w_match[ST_EX]) begin
          if (sb[ST_EX].ld) begin
            hazard = 1'b1;
          end else begin
            sel = SEL_W'(ST_EX);
          end
        end else begin
          for (int k = DEPTH - 1; k > ST_EX; k--) begin
            if (w_match[k]) begin
              sel = SEL_W'(k);
            end
          end
        end
      end
    end else begin : g_stall
      // No bypass network: any in-flight producer holds decode
      always_comb begin
        hazard = |w_match;
        sel    = '0;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl
// Brief  : Pipeline control unit: destination scoreboard, RAW hazard
//          detection with optional forwarding, and halt/drain sequencing.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int               DEPTH    = 5,
  parameter int               RA_W     = 5,
  parameter int               OPC_W    = 6,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_W'(pipe_pkg::HALT_OPC),
  parameter int               FWD_EN   = 1,
  parameter int               SEL_W    = 3
) (
  input wire logic   clk,
  input wire logic   clr,
  pipe_ctrl_if.slave bus
);

  import pipe_pkg::*;

  sb_entry_t        r_sb [ST_EX:DEPTH-1];
  sb_entry_t        w_sb_in;
  logic             r_halted;
  logic             r_done;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_stall;
  logic             w_accept;
  logic             w_halt_opc;
  logic             w_pc_en;
  logic [SEL_W-1:0] w_sel1;
  logic [SEL_W-1:0] w_sel2;
  logic [DEPTH-1:0] w_stage_valid;

  pipe_fwd_match #(
    .DEPTH  (DEPTH),
    .RA_W   (RA_W),
    .SEL_W  (SEL_W),
    .FWD_EN (FWD_EN)
  ) u_match1 (
    .sb     (r_sb),
    .rs     (bus.id_rs1),
    .use_rs (bus.id_use1),
    .hazard (w_haz1),
    .sel    (w_sel1)
  );

  pipe_fwd_match #(
    .DEPTH  (DEPTH),
    .RA_W   (RA_W),
    .SEL_W  (SEL_W),
    .FWD_EN (FWD_EN)
  ) u_match2 (
    .sb     (r_sb),
    .rs     (bus.id_rs2),
    .use_rs (bus.id_use2),
    .hazard (w_haz2),
    .sel    (w_sel2)
  );

  // Stall/accept decisions; once halted, decode is ignored entirely
  always_comb begin
    w_halt_opc = (bus.id_opc == HALT_OPC);
    w_stall    = bus.id_valid & (w_haz1 | w_haz2) & ~r_halted;
    w_accept   = bus.id_valid & ~w_stall & ~r_halted;
    w_pc_en    = ~w_stall & ~r_halted & ~r_done;
  end

  // Entry that enters execute: the decoded instruction or a bubble
  always_comb begin
    w_sb_in = '0;
    if (w_accept) begin
      w_sb_in.valid   = 1'b1;
      w_sb_in.is_halt = w_halt_opc;
      w_sb_in.we      = bus.id_we & ~w_halt_opc;
      w_sb_in.ld      = bus.id_ld & ~w_halt_opc;
      w_sb_in.rd      = w_halt_opc ? '0 : RA_W_MAX'(bus.id_rd);
    end
  end

  // Scoreboard shift: everything from execute onwards advances every edge
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int k = ST_EX; k < DEPTH; k++) begin
        r_sb[k] <= '0;
      end
    end else begin
      r_sb[ST_EX] <= w_sb_in;
      for (int k = ST_EX + 1; k < DEPTH; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  // Halted latches when the halt instruction leaves decode
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_halted <= 1'b0;
    end else if (w_accept && w_halt_opc) begin
      r_halted <= 1'b1;
    end
  end

  // Done latches as the halt instruction retires out of writeback
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_done <= 1'b0;
    end else if (r_sb[DEPTH-1].valid && r_sb[DEPTH-1].is_halt) begin
      r_done <= 1'b1;
    end
  end

  // Per-stage valid vector: fetch/decode from live controls, rest from entries
  always_comb begin
    w_stage_valid        = '0;
    w_stage_valid[ST_IF] = w_pc_en;
    w_stage_valid[ST_ID] = bus.id_valid;
    for (int k = ST_EX; k < DEPTH; k++) begin
      w_stage_valid[k] = r_sb[k].valid;
    end
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.stall       = w_stall;
  assign bus.bubble      = w_stall;
  assign bus.fwd1_sel    = w_sel1;
  assign bus.fwd2_sel    = w_sel2;
  assign bus.stage_valid = w_stage_valid;
  assign bus.halted      = r_halted;
  assign bus.done        = r_done;

endmodule
`default_nettype wire
